// File: rtl/cond_pkg.sv
// rtl/cond_pkg.sv - shared types and constants for the conditional-execution stage
//   cond_e  : ARM condition field encoding, Instr[31:28]
//   FLAG_*  : bit positions of N, Z, C, V within a {N,Z,C,V} flags vector
package cond_pkg;

  typedef enum logic [3:0] {
    EQ = 4'b0000,
    NE = 4'b0001,
    CS = 4'b0010,
    CC = 4'b0011,
    MI = 4'b0100,
    PL = 4'b0101,
    VS = 4'b0110,
    VC = 4'b0111,
    HI = 4'b1000,
    LS = 4'b1001,
    GE = 4'b1010,
    LT = 4'b1011,
    GT = 4'b1100,
    LE = 4'b1101,
    AL = 4'b1110,
    NV = 4'b1111
  } cond_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/cond_unit_if.sv
// rtl/cond_unit_if.sv - decoder/ALU to conditional-execution stage bundle
//   master : decoder/ALU side, drives Cond, ALUFlags, FlagW, PCS, RegW, MemW,
//            NoWrite, InstMem; observes the gated strobes, Flags, CondEx, MemFault
//   slave  : cond_unit side, the mirror image
interface cond_unit_if;
  import cond_pkg::*;

  logic [3:0] Cond;
  logic [3:0] ALUFlags;
  logic [1:0] FlagW;
  logic       PCS;
  logic       RegW;
  logic       MemW;
  logic       NoWrite;
  logic       InstMem;

  logic       PCSrc;
  logic       RegWrite;
  logic       MemWrite;
  logic [3:0] Flags;
  logic       CondEx;
  logic       MemFault;

  modport master (
    output Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite, InstMem,
    input  PCSrc, RegWrite, MemWrite, Flags, CondEx, MemFault
  );

  modport slave (
    input  Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite, InstMem,
    output PCSrc, RegWrite, MemWrite, Flags, CondEx, MemFault
  );

endinterface

// File: rtl/cond_check.sv
// rtl/cond_check.sv - combinational condition-field evaluator
//   cond    in  4 : condition field
//   flags   in  4 : {N,Z,C,V}
//   cond_ex out 1 : condition holds for these flags
module cond_check
  import cond_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       cond_ex
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    cond_ex = 1'b0;
    case (cond_e'(cond))
      EQ:      cond_ex = z;
      NE:      cond_ex = ~z;
      CS:      cond_ex = c;
      CC:      cond_ex = ~c;
      MI:      cond_ex = n;
      PL:      cond_ex = ~n;
      VS:      cond_ex = v;
      VC:      cond_ex = ~v;
      HI:      cond_ex = c & ~z;
      LS:      cond_ex = ~c | z;
      GE:      cond_ex = ~(n ^ v);
      LT:      cond_ex = n ^ v;
      GT:      cond_ex = ~z & ~(n ^ v);
      LE:      cond_ex = z | (n ^ v);
      AL:      cond_ex = 1'b1;
      // NV is reserved and never executes
      default: cond_ex = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_unit.sv
// rtl/cond_unit.sv - flags register, condition gating and instruction-memory write guard
//   clk   in      : rising-edge clock
//   reset in      : asynchronous active-low reset
//   bus   slave   : Cond/ALUFlags/FlagW/PCS/RegW/MemW/NoWrite/InstMem in,
//                   PCSrc/RegWrite/MemWrite/Flags/CondEx/MemFault out
module cond_unit
  import cond_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  cond_unit_if.slave  bus
);

  logic [1:0] flags_nz_q, flags_nz_d;
  logic [1:0] flags_cv_q, flags_cv_d;
  logic       mem_fault_q, mem_fault_d;
  logic       cond_ex;
  logic       inst_mem_write;

  // Condition is tested against the flags from before this instruction.
  cond_check u_cond_check (
    .cond    (bus.Cond),
    .flags   ({flags_nz_q, flags_cv_q}),
    .cond_ex (cond_ex)
  );

  assign inst_mem_write = bus.MemW & cond_ex & bus.InstMem;

  always_comb begin
    flags_nz_d  = flags_nz_q;
    flags_cv_d  = flags_cv_q;
    mem_fault_d = mem_fault_q | inst_mem_write;
    // NZ and CV halves load independently so logical ops can keep C/V.
    if (bus.FlagW[1] && cond_ex) flags_nz_d = bus.ALUFlags[FLAG_N:FLAG_Z];
    if (bus.FlagW[0] && cond_ex) flags_cv_d = bus.ALUFlags[FLAG_C:FLAG_V];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags_nz_q  <= 2'b00;
      flags_cv_q  <= 2'b00;
      mem_fault_q <= 1'b0;
    end else begin
      flags_nz_q  <= flags_nz_d;
      flags_cv_q  <= flags_cv_d;
      mem_fault_q <= mem_fault_d;
    end
  end

  assign bus.CondEx   = cond_ex;
  assign bus.PCSrc    = bus.PCS & cond_ex;
  assign bus.RegWrite = bus.RegW & cond_ex & ~bus.NoWrite;
  assign bus.MemWrite = bus.MemW & cond_ex & ~bus.InstMem;
  assign bus.Flags    = {flags_nz_q, flags_cv_q};
  assign bus.MemFault = mem_fault_q;

endmodule
